alu_issue_seq: RTL

- Multi-cycle issue/sequencer that drives the 16-bit ALU from the controller side.
- Accepts one 16-bit instruction per handshake and decodes it into ALU op/eq/ltgt controls.
- Supplies operands from an internal 8x16 register file, captures the ALU result and compare bit, and writes back.
- Maintains the program counter and a sticky compare flag used by flag-branch instructions.

---
 rtl/alu_issue_seq_if.sv | 24 ++
 rtl/alu_issue_seq.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/alu_issue_seq_if.sv
// Bundles the instruction handshake and the ALU control/result bus of alu_issue_seq.
// The slave side is the sequencer; the master side is the controller plus the ALU it drives.
interface alu_issue_seq_if;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic        alu_eq;
    logic [2:0]  alu_ltgt;
    logic [15:0] alu_out;
    logic        alu_compres;

    modport master (
        output instr_valid, instr, alu_out, alu_compres,
        input  instr_ready, alu_op, alu_a, alu_b, alu_eq, alu_ltgt
    );

    modport slave (
        input  instr_valid, instr, alu_out, alu_compres,
        output instr_ready, alu_op, alu_a, alu_b, alu_eq, alu_ltgt
    );
endinterface

// File: rtl/alu_issue_seq.sv
// Four-state issue sequencer: accepts one instruction, drives the external ALU from an
// 8x16 register file, writes the result back and advances the PC (fixed 3-cycle latency).
module alu_issue_seq #(
    parameter int PC_W = 8,
    parameter int NREG = 8
) (
    input  logic            clock,
    input  logic            reset_n,
    alu_issue_seq_if.slave  bus,
    output logic [PC_W-1:0] pc,
    output logic            flag,
    output logic            done,
    output logic            illegal,
    input  logic [2:0]      dbg_addr,
    output logic [15:0]     dbg_data
);
    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    localparam logic [3:0] OP_IDLE = 4'b1111;

    state_t          state_q, state_d;
    logic [15:0]     instr_q, instr_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [15:0]     alu_a_q, alu_a_d;
    logic [15:0]     alu_b_q, alu_b_d;
    logic            alu_eq_q, alu_eq_d;
    logic [2:0]      alu_ltgt_q, alu_ltgt_d;
    logic [15:0]     result_q, result_d;
    logic            flag_q, flag_d;
    logic            illegal_q, illegal_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     rf_q [NREG];
    logic [15:0]     rf_d [NREG];

    logic [3:0]      opc;
    logic [2:0]      f_hi, f_mid, f_lo;
    logic            rf_wr;
    logic [PC_W-1:0] bf_off;

    assign opc    = instr_q[15:12];
    assign f_hi   = instr_q[11:9];
    assign f_mid  = instr_q[8:6];
    assign f_lo   = instr_q[5:3];
    assign rf_wr  = (opc <= 4'd4) || (opc == 4'd6);
    assign bf_off = PC_W'($signed(instr_q[7:0]));

    assign bus.instr_ready = (state_q == IDLE);
    assign bus.alu_op      = alu_op_q;
    assign bus.alu_a       = alu_a_q;
    assign bus.alu_b       = alu_b_q;
    assign bus.alu_eq      = alu_eq_q;
    assign bus.alu_ltgt    = alu_ltgt_q;
    assign pc              = pc_q;
    assign flag            = flag_q;
    assign done            = (state_q == WB);
    assign illegal         = illegal_q;
    assign dbg_data        = rf_q[dbg_addr];

    always_comb begin
        state_d    = state_q;
        instr_d    = instr_q;
        alu_op_d   = alu_op_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_eq_d   = alu_eq_q;
        alu_ltgt_d = alu_ltgt_q;
        result_d   = result_q;
        flag_d     = flag_q;
        illegal_d  = illegal_q;
        pc_d       = pc_q;
        rf_d       = rf_q;

        case (state_q)
            IDLE: begin
                if (bus.instr_valid) begin
                    instr_d = bus.instr;
                    state_d = DECODE;
                end
            end
            DECODE: begin
                alu_op_d   = OP_IDLE;
                alu_eq_d   = 1'b1;
                alu_ltgt_d = 3'd0;
                if (opc <= 4'd4) begin
                    alu_a_d  = rf_q[f_mid];
                    alu_b_d  = rf_q[f_lo];
                    alu_op_d = (opc == 4'd1) ? 4'd0 : opc;
                    alu_eq_d = (opc != 4'd1);
                end else if (opc == 4'd5) begin
                    alu_a_d    = rf_q[f_hi];
                    alu_b_d    = rf_q[f_mid];
                    alu_op_d   = 4'd5;
                    alu_eq_d   = ~f_lo[2];
                    alu_ltgt_d = {1'b0, f_lo[1:0]};
                end
                state_d = EXEC;
            end
            EXEC: begin
                result_d = (opc == 4'd6) ? {8'h00, instr_q[7:0]} : bus.alu_out;
                // Conditions 3 and 7 are undefined compares and always clear the flag.
                if (opc == 4'd5) begin
                    flag_d = (f_lo[1:0] != 2'b11) && bus.alu_compres;
                end
                state_d = WB;
            end
            WB: begin
                if (rf_wr && (f_hi != 3'd0)) begin
                    rf_d[f_hi] = result_q;
                end
                if ((opc == 4'd7) && flag_q) begin
                    pc_d = pc_q + bf_off;
                end else begin
                    pc_d = pc_q + PC_W'(1);
                end
                if (opc[3]) begin
                    illegal_d = 1'b1;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            instr_q    <= '0;
            alu_op_q   <= OP_IDLE;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_eq_q   <= 1'b1;
            alu_ltgt_q <= '0;
            result_q   <= '0;
            flag_q     <= 1'b0;
            illegal_q  <= 1'b0;
            pc_q       <= '0;
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            instr_q    <= instr_d;
            alu_op_q   <= alu_op_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_eq_q   <= alu_eq_d;
            alu_ltgt_q <= alu_ltgt_d;
            result_q   <= result_d;
            flag_q     <= flag_d;
            illegal_q  <= illegal_d;
            pc_q       <= pc_d;
            rf_q       <= rf_d;
        end
    end
endmodule
